// File: rtl/sdram_burst_sched.sv
// Burst scheduler for the camera->SDRAM->LCD frame buffer: picks one write or read burst at a
// time from FIFO fill levels, walks wrapping frame pointers and manages ping-pong banks.
module sdram_burst_sched #(
    parameter int AW = 24,
    parameter int LW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sdram_init_done,
    input  logic [LW-1:0] wr_fifo_used,
    input  logic [LW-1:0] rd_fifo_used,
    input  logic [AW-1:0] wr_min_addr,
    input  logic [AW-1:0] wr_max_addr,
    input  logic [AW-1:0] rd_min_addr,
    input  logic [AW-1:0] rd_max_addr,
    input  logic [LW-1:0] wr_len,
    input  logic [LW-1:0] rd_len,
    input  logic          wr_load,
    input  logic          rd_load,
    input  logic          read_valid,
    input  logic          pingpang_en,
    input  logic          cmd_ack,
    input  logic          cmd_done,
    output logic          cmd_wr_req,
    output logic          cmd_rd_req,
    output logic [AW-1:0] cmd_addr,
    output logic [LW-1:0] cmd_len,
    output logic          wr_fifo_clr,
    output logic          rd_fifo_clr
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_BUSY = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_BUSY = 3'd4;

    logic [2:0]    state_r;
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic          wr_bank_r, rd_bank_r;
    logic          wr_pend_r, rd_pend_r;
    logic          wr_load_d_r, rd_load_d_r;
    logic          cmd_wr_req_r, cmd_rd_req_r;
    logic [AW-1:0] cmd_addr_r;
    logic [LW-1:0] cmd_len_r;
    logic          wr_fifo_clr_r, rd_fifo_clr_r;

    logic          wr_rise_s, rd_rise_s, apply_win_s, wr_apply_s, rd_apply_s;
    logic          load_block_s, go_wr_s, go_rd_s, wr_wrap_s, rd_wrap_s;
    logic [AW-1:0] wr_nxt_s, rd_nxt_s;

    // Bank bit replaces ba[0] only when double buffering is on.
    function automatic logic [AW-1:0] bank_addr(input logic [AW-1:0] ptr, input logic bank,
                                                 input logic en);
        bank_addr = en ? {ptr[AW-1], bank, ptr[AW-3:0]} : ptr;
    endfunction

    // Load edges, scheduling decision and next-pointer arithmetic.
    always_comb begin
        wr_rise_s    = wr_load & ~wr_load_d_r;
        rd_rise_s    = rd_load & ~rd_load_d_r;
        apply_win_s  = (state_r == ST_IDLE) ||
                       (((state_r == ST_WR_BUSY) || (state_r == ST_RD_BUSY)) && cmd_done);
        wr_apply_s   = apply_win_s & wr_pend_r;
        rd_apply_s   = apply_win_s & rd_pend_r;
        load_block_s = wr_pend_r | rd_pend_r | wr_rise_s | rd_rise_s;
        go_wr_s      = (state_r == ST_IDLE) && sdram_init_done && !load_block_s &&
                       (wr_fifo_used >= wr_len);
        go_rd_s      = (state_r == ST_IDLE) && sdram_init_done && !load_block_s && !go_wr_s &&
                       read_valid && (rd_fifo_used < rd_len);
        wr_nxt_s     = wr_ptr_r + {{(AW-LW){1'b0}}, wr_len};
        rd_nxt_s     = rd_ptr_r + {{(AW-LW){1'b0}}, rd_len};
        // One extra bit so nxt+len cannot overflow before comparing with the frame end.
        wr_wrap_s    = ({1'b0, wr_nxt_s} + {{(AW+1-LW){1'b0}}, wr_len}) > {1'b0, wr_max_addr};
        rd_wrap_s    = ({1'b0, rd_nxt_s} + {{(AW+1-LW){1'b0}}, rd_len}) > {1'b0, rd_max_addr};
    end

    // Pointers, banks, load handling and the request FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= wr_min_addr;
            rd_ptr_r      <= rd_min_addr;
            wr_bank_r     <= 1'b0;
            rd_bank_r     <= 1'b1;
            wr_pend_r     <= 1'b0;
            rd_pend_r     <= 1'b0;
            wr_load_d_r   <= 1'b0;
            rd_load_d_r   <= 1'b0;
            cmd_wr_req_r  <= 1'b0;
            cmd_rd_req_r  <= 1'b0;
            cmd_addr_r    <= {AW{1'b0}};
            cmd_len_r     <= {LW{1'b0}};
            wr_fifo_clr_r <= 1'b0;
            rd_fifo_clr_r <= 1'b0;
        end else begin
            wr_load_d_r   <= wr_load;
            rd_load_d_r   <= rd_load;
            wr_fifo_clr_r <= wr_apply_s;
            rd_fifo_clr_r <= rd_apply_s;
            wr_pend_r     <= wr_apply_s ? wr_rise_s : (wr_pend_r | wr_rise_s);
            rd_pend_r     <= rd_apply_s ? rd_rise_s : (rd_pend_r | rd_rise_s);

            // A pending load beats the pointer advance of the burst completing now.
            if (wr_apply_s) begin
                wr_ptr_r  <= wr_min_addr;
                wr_bank_r <= 1'b0;
            end else if ((state_r == ST_WR_BUSY) && cmd_done) begin
                wr_ptr_r <= wr_wrap_s ? wr_min_addr : wr_nxt_s;
                if (wr_wrap_s && pingpang_en) begin
                    wr_bank_r <= ~wr_bank_r;
                end
            end

            if (rd_apply_s) begin
                rd_ptr_r  <= rd_min_addr;
                rd_bank_r <= 1'b1;
            end else if ((state_r == ST_RD_BUSY) && cmd_done) begin
                rd_ptr_r <= rd_wrap_s ? rd_min_addr : rd_nxt_s;
                if (rd_wrap_s && pingpang_en) begin
                    rd_bank_r <= ~wr_bank_r;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (go_wr_s) begin
                        state_r      <= ST_WR_REQ;
                        cmd_wr_req_r <= 1'b1;
                        cmd_addr_r   <= bank_addr(wr_ptr_r, wr_bank_r, pingpang_en);
                        cmd_len_r    <= wr_len;
                    end else if (go_rd_s) begin
                        state_r      <= ST_RD_REQ;
                        cmd_rd_req_r <= 1'b1;
                        cmd_addr_r   <= bank_addr(rd_ptr_r, rd_bank_r, pingpang_en);
                        cmd_len_r    <= rd_len;
                    end
                end
                ST_WR_REQ: begin
                    if (cmd_ack) begin
                        state_r      <= ST_WR_BUSY;
                        cmd_wr_req_r <= 1'b0;
                    end
                end
                ST_RD_REQ: begin
                    if (cmd_ack) begin
                        state_r      <= ST_RD_BUSY;
                        cmd_rd_req_r <= 1'b0;
                    end
                end
                ST_WR_BUSY, ST_RD_BUSY: begin
                    if (cmd_done) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cmd_wr_req_r <= 1'b0;
                    cmd_rd_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_wr_req  = cmd_wr_req_r;
    assign cmd_rd_req  = cmd_rd_req_r;
    assign cmd_addr    = cmd_addr_r;
    assign cmd_len     = cmd_len_r;
    assign wr_fifo_clr = wr_fifo_clr_r;
    assign rd_fifo_clr = rd_fifo_clr_r;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Directed bench for sdram_burst_sched: hand-computed addresses, priorities, bank flips,
// load/clear sequencing, init gating and mid-burst reset.
module tb_sdram_burst_sched;

    localparam int AW = 24;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          sdram_init_done;
    logic [LW-1:0] wr_fifo_used, rd_fifo_used, wr_len, rd_len;
    logic [AW-1:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;
    logic          wr_load, rd_load, read_valid, pingpang_en, cmd_ack, cmd_done;
    logic          cmd_wr_req, cmd_rd_req, wr_fifo_clr, rd_fifo_clr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;

    int checks = 0;
    int errors = 0;

    sdram_burst_sched #(.AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .sdram_init_done(sdram_init_done),
        .wr_fifo_used(wr_fifo_used), .rd_fifo_used(rd_fifo_used),
        .wr_min_addr(wr_min_addr), .wr_max_addr(wr_max_addr),
        .rd_min_addr(rd_min_addr), .rd_max_addr(rd_max_addr),
        .wr_len(wr_len), .rd_len(rd_len), .wr_load(wr_load), .rd_load(rd_load),
        .read_valid(read_valid), .pingpang_en(pingpang_en),
        .cmd_ack(cmd_ack), .cmd_done(cmd_done),
        .cmd_wr_req(cmd_wr_req), .cmd_rd_req(cmd_rd_req),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_fifo_clr(wr_fifo_clr), .rd_fifo_clr(rd_fifo_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the selected request to rise; a timeout is a failed check.
    task automatic wait_req(input string tag, input bit is_wr);
        int n;
        n = 0;
        while (((is_wr ? cmd_wr_req : cmd_rd_req) !== 1'b1) && (n < 20)) begin
            tick();
            n++;
        end
        check(tag, {31'd0, (is_wr ? cmd_wr_req : cmd_rd_req)}, 32'd1);
    endtask

    task automatic ack_done();
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        tick();
        tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_req"}, {31'd0, cmd_wr_req}, 32'd0);
        check({tag, "_rd_req"}, {31'd0, cmd_rd_req}, 32'd0);
        check({tag, "_addr"}, {8'd0, cmd_addr}, 32'd0);
        check({tag, "_len"}, {22'd0, cmd_len}, 32'd0);
        check({tag, "_clr"}, {30'd0, wr_fifo_clr, rd_fifo_clr}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; sdram_init_done = 1'b1;
        wr_fifo_used = 10'd0; rd_fifo_used = 10'd1023;
        wr_min_addr = 24'd0; wr_max_addr = 24'd2048;
        rd_min_addr = 24'd0; rd_max_addr = 24'd256;
        wr_len = 10'd512; rd_len = 10'd256;
        wr_load = 1'b0; rd_load = 1'b0; read_valid = 1'b0; pingpang_en = 1'b0;
        cmd_ack = 1'b0; cmd_done = 1'b0;
        tick();
        tick();
        check_all_zero("reset");

        // 1: first write request one cycle after the decision, then sequential address
        wr_fifo_used = 10'd512;
        rst = 1'b0;
        tick();
        check("t1_wr_req", {31'd0, cmd_wr_req}, 32'd1);
        check("t1_addr0", {8'd0, cmd_addr}, 32'd0);
        check("t1_len", {22'd0, cmd_len}, 32'd512);
        ack_done();
        wait_req("t1_wr_req2", 1'b1);
        check("t1_addr1", {8'd0, cmd_addr}, 32'd512);

        // 2: write has priority over a starving read
        wr_fifo_used = 10'd600; rd_fifo_used = 10'd0; read_valid = 1'b1;
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check("t2_req_dropped", {31'd0, cmd_wr_req}, 32'd0);
        tick();
        check("t2_no_rd_busy", {31'd0, cmd_rd_req}, 32'd0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        wait_req("t2_wr_again", 1'b1);
        check("t2_rd_held", {31'd0, cmd_rd_req}, 32'd0);
        check("t2_addr2", {8'd0, cmd_addr}, 32'd1024);
        wr_fifo_used = 10'd100;
        ack_done();
        wait_req("t2_rd_req", 1'b0);
        check("t2_rd_addr", {8'd0, cmd_addr}, 32'd0);
        check("t2_rd_len", {22'd0, cmd_len}, 32'd256);
        ack_done();
        read_valid = 1'b0;

        // 3: ping-pong write frame wrap sets bank bit 22
        rst = 1'b1; pingpang_en = 1'b1; wr_fifo_used = 10'd512;
        tick();
        check_all_zero("t3_reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_req($sformatf("t3_req%0d", i), 1'b1);
            check($sformatf("t3_addr%0d", i), {8'd0, cmd_addr}, 32'(i * 512));
            ack_done();
        end
        wait_req("t3_req_wrap", 1'b1);
        check("t3_addr_wrap", {8'd0, cmd_addr}, 32'h0040_0000);
        ack_done();
        wr_fifo_used = 10'd0;

        // 4: read wrap while wr_bank=1 selects bank 0
        read_valid = 1'b1; rd_fifo_used = 10'd0;
        wait_req("t4_rd_req0", 1'b0);
        check("t4_rd_addr0", {8'd0, cmd_addr}, 32'h0040_0000);
        ack_done();
        wait_req("t4_rd_req1", 1'b0);
        check("t4_rd_addr1", {8'd0, cmd_addr}, 32'h0000_0000);
        ack_done();
        read_valid = 1'b0;

        // 5: load during a burst waits for cmd_done, then clears and restarts at wr_min
        wr_min_addr = 24'd256; wr_fifo_used = 10'd512;
        wait_req("t5_wr_req", 1'b1);
        check("t5_addr", {8'd0, cmd_addr}, 32'h0040_0200);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        wr_load = 1'b1;
        tick();
        check("t5_no_clr_a", {31'd0, wr_fifo_clr}, 32'd0);
        tick();
        check("t5_no_clr_b", {31'd0, wr_fifo_clr}, 32'd0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check("t5_clr", {31'd0, wr_fifo_clr}, 32'd1);
        check("t5_rd_clr", {31'd0, rd_fifo_clr}, 32'd0);
        tick();
        check("t5_clr_pulse", {31'd0, wr_fifo_clr}, 32'd0);
        wait_req("t5_wr_req2", 1'b1);
        check("t5_addr_min", {8'd0, cmd_addr}, 32'd256);
        wr_load = 1'b0;

        // 6: init_done low blocks requests; reset mid read burst clears outputs
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        sdram_init_done = 1'b0; wr_fifo_used = 10'd1023; rd_fifo_used = 10'd0;
        read_valid = 1'b1;
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6_no_req%0d", i), {30'd0, cmd_wr_req, cmd_rd_req}, 32'd0);
        end
        wr_fifo_used = 10'd0; sdram_init_done = 1'b1;
        wait_req("t6_rd_req", 1'b0);
        check("t6_rd_len", {22'd0, cmd_len}, 32'd256);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        rst = 1'b1;
        tick();
        check_all_zero("t6_rst");
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
